// File: rtl/tw_req_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : tw_req_arbiter_pkg
// Brief  : Shared constants and arbiter state type for the taskwait request path.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package tw_req_arbiter_pkg;

    localparam int MAX_ACCS = 16;
    localparam int ACC_ID_W = $clog2(MAX_ACCS);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    typedef enum logic [0:0] {
        ARB  = ST_ARB,
        XFER = ST_XFER
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/tw_rr_pick.sv
//------------------------------------------------------------------------------
// Module : tw_rr_pick
// Brief  : Combinational round-robin selector; first requester after 'last' wins.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tw_rr_pick
    import tw_req_arbiter_pkg::*;
#(
    parameter int NUM_IN = MAX_ACCS,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IDX_W-1:0]  last_i,
    output logic              any_o,
    output logic [IDX_W-1:0]  idx_o
);

    logic [IDX_W-1:0] cand_idx;

    // Walk from the farthest candidate to the nearest so the nearest match is written last.
    always_comb begin
        any_o    = 1'b0;
        idx_o    = '0;
        cand_idx = '0;
        for (int k = NUM_IN; k >= 1; k--) begin
            cand_idx = IDX_W'((int'(last_i) + k) % NUM_IN);
            if (req_i[cand_idx]) begin
                any_o = 1'b1;
                idx_o = cand_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tw_req_arbiter.sv
//------------------------------------------------------------------------------
// Module : tw_req_arbiter
// Brief  : Round-robin, packet-locked stream arbiter tagging beats with the port id.
//          Optional per-port packet counters under macro TW_ARB_STATS_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tw_req_arbiter
    import tw_req_arbiter_pkg::*;
#(
    parameter int NUM_IN    = MAX_ACCS,
    parameter int ID_W      = ACC_ID_W,
    parameter int DATA_W    = 64,
    parameter int PKT_BEATS = 2
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [NUM_IN*DATA_W-1:0] inStream_TDATA,
    input  logic [NUM_IN-1:0]        inStream_TVALID,
    output logic [NUM_IN-1:0]        inStream_TREADY,
    output logic [DATA_W-1:0]        outStream_TDATA,
    output logic                     outStream_TVALID,
    output logic [ID_W-1:0]          outStream_TID,
    input  logic                     outStream_TREADY
`ifdef TW_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]          stats_sel,
    output logic [31:0]              stats_cnt,
    input  logic                     stats_clr
`endif
);

    localparam int               GNT_W     = $clog2(NUM_IN);
    localparam int               CNT_W     = $clog2(PKT_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_BEATS - 1);
    localparam logic [GNT_W-1:0] LAST_PORT = GNT_W'(NUM_IN - 1);

    arb_state_e       state_q, state_d;
    logic [GNT_W-1:0] grant_q, grant_d;
    logic [GNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    logic [DATA_W-1:0] lane [NUM_IN];
    logic              pick_any;
    logic [GNT_W-1:0]  pick_idx;
    logic              in_xfer;
    logic              hs;
    logic              pkt_done;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
            assign lane[gi] = inStream_TDATA[gi*DATA_W +: DATA_W];
        end
    endgenerate

    tw_rr_pick #(
        .NUM_IN (NUM_IN),
        .IDX_W  (GNT_W)
    ) u_pick (
        .req_i  (inStream_TVALID),
        .last_i (last_q),
        .any_o  (pick_any),
        .idx_o  (pick_idx)
    );

    assign in_xfer  = (state_q == XFER);
    assign hs       = in_xfer && inStream_TVALID[grant_q] && outStream_TREADY;
    assign pkt_done = hs && (beat_q == LAST_BEAT);

    // Pure pass-through while locked; nothing is forwarded during the arbitration bubble.
    always_comb begin
        outStream_TVALID = 1'b0;
        outStream_TDATA  = '0;
        outStream_TID    = '0;
        inStream_TREADY  = '0;
        if (in_xfer) begin
            outStream_TVALID             = inStream_TVALID[grant_q];
            outStream_TDATA              = lane[grant_q];
            outStream_TID[GNT_W-1:0]     = grant_q;
            inStream_TREADY[grant_q]     = outStream_TREADY;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            ARB: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    beat_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (pkt_done) begin
                    last_d  = grant_q;
                    beat_d  = '0;
                    state_d = ARB;
                end else if (hs) begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= ARB;
            grant_q <= '0;
            last_q  <= LAST_PORT;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

`ifdef TW_ARB_STATS_EN
    logic [31:0] stats_q [NUM_IN];

    // Clear has priority over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge ap_clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (!ap_rst_n || stats_clr) begin
                stats_q[i] <= '0;
            end else if (pkt_done && (grant_q == GNT_W'(i)) && (stats_q[i] != 32'hFFFF_FFFF)) begin
                stats_q[i] <= stats_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            stats_cnt <= '0;
        end else if (int'(stats_sel) < NUM_IN) begin
            stats_cnt <= stats_q[stats_sel[GNT_W-1:0]];
        end else begin
            stats_cnt <= '0;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tw_req_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_tw_req_arbiter
// Brief  : Scoreboard bench for tw_req_arbiter with directed and random traffic.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tw_req_arbiter;

    localparam int NUM_IN    = 16;
    localparam int ID_W      = 4;
    localparam int DATA_W    = 64;
    localparam int PKT_BEATS = 2;
    localparam int DEPTH     = 256;

    logic                     ap_clk;
    logic                     ap_rst_n;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        vld;
    logic [NUM_IN-1:0]        in_rdy;
    logic [DATA_W-1:0]        out_data;
    logic                     out_vld;
    logic [ID_W-1:0]          out_tid;
    logic                     ds_rdy;

    tw_req_arbiter #(
        .NUM_IN    (NUM_IN),
        .ID_W      (ID_W),
        .DATA_W    (DATA_W),
        .PKT_BEATS (PKT_BEATS)
    ) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .inStream_TDATA   (in_data),
        .inStream_TVALID  (vld),
        .inStream_TREADY  (in_rdy),
        .outStream_TDATA  (out_data),
        .outStream_TVALID (out_vld),
        .outStream_TID    (out_tid),
        .outStream_TREADY (ds_rdy)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                tid;
        bit                last;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] mem [NUM_IN][DEPTH];
    int                wr_ptr [NUM_IN];
    int                rd_ptr [NUM_IN];
    int                vld_pct;
    int                n_total;
    int                n_bad;
    int                pkt_done;

    // Reference model state: idle/busy, granted port, previous winner, beats moved.
    bit m_busy;
    int m_grant;
    int m_last;
    int m_cnt;

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        bit pend;
        for (int p = 0; p < NUM_IN; p++) begin
            pend = rd_ptr[p] < wr_ptr[p];
            vld[p] = pend && ($urandom_range(99) < vld_pct);
            in_data[p*DATA_W +: DATA_W] = pend ? mem[p][rd_ptr[p]] : '0;
        end
    endtask

    task automatic add_packet(input int p, input logic [DATA_W-1:0] hdr, input logic [DATA_W-1:0] tid);
        if (wr_ptr[p] + PKT_BEATS <= DEPTH) begin
            for (int b = 0; b < PKT_BEATS; b++)
                mem[p][wr_ptr[p] + b] = (b == 0) ? hdr : tid;
            wr_ptr[p] += PKT_BEATS;
        end
    endtask

    // One clock: sources observe their own handshake, then present the next beat.
    task automatic step();
        bit hs [NUM_IN];
        @(negedge ap_clk);
        for (int p = 0; p < NUM_IN; p++)
            hs[p] = ap_rst_n && vld[p] && in_rdy[p];
        @(posedge ap_clk);
        #1;
        for (int p = 0; p < NUM_IN; p++)
            if (hs[p]) rd_ptr[p]++;
        drive();
    endtask

    task automatic clear_sources();
        for (int p = 0; p < NUM_IN; p++) begin
            wr_ptr[p] = 0;
            rd_ptr[p] = 0;
        end
        drive();
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        clear_sources();
        repeat (2) step();
        ap_rst_n = 1'b1;
    endtask

    function automatic bit sources_empty();
        for (int p = 0; p < NUM_IN; p++)
            if (rd_ptr[p] != wr_ptr[p]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        vld_pct = 100;
        ds_rdy = 1'b1;
        drive();
        while (n < max_cyc && !(sources_empty() && !m_busy && exp_q.size() == 0)) begin
            step();
            n++;
        end
        check("drain_idle", {61'd0, sources_empty(), !m_busy, exp_q.size() == 0}, 64'd7);
    endtask

    task automatic wait_beat0(input int p);
        int n;
        n = 0;
        while (rd_ptr[p] < 1 && n < 50) begin
            step();
            n++;
        end
        check("wait_beat0_timeout", {63'd0, rd_ptr[p] >= 1}, 64'd1);
    endtask

    // Reference model: round-robin search from last winner + 1, lock for PKT_BEATS handshakes.
    initial begin
        m_busy  = 1'b0;
        m_last  = NUM_IN - 1;
        m_grant = 0;
        m_cnt   = 0;
        forever begin
            @(posedge ap_clk);
            if (!ap_rst_n) begin
                m_busy = 1'b0;
                m_last = NUM_IN - 1;
                m_cnt  = 0;
                exp_q.delete();
            end else if (!m_busy) begin
                for (int k = 1; k <= NUM_IN; k++) begin
                    int c;
                    c = (m_last + k) % NUM_IN;
                    if (vld[c]) begin
                        m_busy  = 1'b1;
                        m_grant = c;
                        m_cnt   = 0;
                        for (int b = 0; b < PKT_BEATS; b++)
                            exp_q.push_back('{mem[c][rd_ptr[c] + b], c, b == PKT_BEATS - 1});
                        break;
                    end
                end
            end else if (vld[m_grant] && ds_rdy) begin
                m_cnt++;
                if (m_cnt == PKT_BEATS) begin
                    m_busy = 1'b0;
                    m_last = m_grant;
                end
            end
        end
    end

    // Monitor: per-cycle handshake signals, and pops the scoreboard on every accepted beat.
    initial begin
        logic              e_tv;
        logic [NUM_IN-1:0] e_tr;
        exp_t              e;
        forever begin
            @(negedge ap_clk);
            e_tv = m_busy ? vld[m_grant] : 1'b0;
            e_tr = '0;
            if (m_busy && ds_rdy) e_tr[m_grant] = 1'b1;
            check("out_tvalid", {63'd0, out_vld}, {63'd0, e_tv});
            check("in_tready", {48'd0, in_rdy}, {48'd0, e_tr});
            if (ap_rst_n && out_vld && ds_rdy) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got tid=%0d data=%0h expected no beat", out_tid, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", out_data, e.data);
                    check("beat_tid", {60'd0, out_tid}, 64'(e.tid));
                    if (e.last) pkt_done++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        n_total  = 0;
        n_bad    = 0;
        pkt_done = 0;
        vld_pct  = 100;
        ds_rdy   = 1'b1;
        ap_rst_n = 1'b0;
        vld      = '0;
        in_data  = '0;

        // Reset state
        do_reset();
        #2;
        check("reset_tvalid", {63'd0, out_vld}, 64'd0);
        check("reset_tready", {48'd0, in_rdy}, 64'd0);

        // Single packet from port 3
        add_packet(3, 64'h5, 64'hDEAD_BEEF);
        drive();
        step();
        #2;
        check("single_first_valid", {63'd0, out_vld}, 64'd1);
        check("single_tid", {60'd0, out_tid}, 64'd3);
        check("single_hdr", out_data, 64'h5);
        drain(50);

        // Ports 0, 5, 9 together: three packets in nine cycles
        do_reset();
        add_packet(0, 64'h100, 64'hA0);
        add_packet(5, 64'h105, 64'hA5);
        add_packet(9, 64'h109, 64'hA9);
        drive();
        p0 = pkt_done;
        repeat (9) step();
        check("three_pkts_9cyc", 64'(pkt_done - p0), 64'd3);
        drain(50);

        // Lock: port 1 arrives between beats of port 2
        add_packet(2, 64'h202, 64'hB2);
        drive();
        wait_beat0(2);
        add_packet(1, 64'h201, 64'hB1);
        drive();
        #2;
        check("lock_tid", {60'd0, out_tid}, 64'd2);
        check("lock_rdy1", {63'd0, in_rdy[1]}, 64'd0);
        drain(50);

        // Backpressure and wrap: last winner 15, ports 15 and 0 compete
        do_reset();
        add_packet(15, 64'h30F, 64'hCF);
        drain(50);
        add_packet(15, 64'h40F, 64'hDF);
        add_packet(0, 64'h400, 64'hD0);
        ds_rdy = 1'b0;
        drive();
        step();
        repeat (5) begin
            step();
            #2;
            check("stall_tvalid", {63'd0, out_vld}, 64'd1);
            check("stall_tid", {60'd0, out_tid}, 64'd0);
            check("stall_data", out_data, 64'h400);
        end
        drain(50);

        // Reset in the middle of a port 7 packet
        do_reset();
        add_packet(7, 64'h507, 64'hE7);
        drive();
        wait_beat0(7);
        ap_rst_n = 1'b0;
        clear_sources();
        step();
        #2;
        check("midrst_tvalid", {63'd0, out_vld}, 64'd0);
        check("midrst_tready", {48'd0, in_rdy}, 64'd0);
        step();
        ap_rst_n = 1'b1;
        add_packet(7, 64'h607, 64'hF7);
        add_packet(0, 64'h600, 64'hF0);
        drive();
        step();
        #2;
        check("midrst_prio_tid", {60'd0, out_tid}, 64'd0);
        drain(50);

        // Random traffic with random source gaps and downstream backpressure
        do_reset();
        vld_pct = 70;
        repeat (600) begin
            ds_rdy = ($urandom_range(99) < 75);
            if ($urandom_range(99) < 35)
                add_packet(int'($urandom_range(NUM_IN - 1)), {$urandom, $urandom}, {$urandom, $urandom});
            drive();
            step();
        end
        drain(4000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
